// File: rtl/mux_2x1_rr_arb.sv
// Round-robin arbiter: two valid/ready requesters into one registered output.
// Optional ARB_LOCK_EN adds in_lock to pin the grant to one requester.
module mux_2x1_rr_arb #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
`ifdef ARB_LOCK_EN
   input  logic [1:0]       in_lock,
`endif
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sel
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             sel_q, sel_d;
   logic             prio_q, prio_d;
   logic             load;
   logic             v0_elig, v1_elig;
   logic             grant, pick1;

`ifdef ARB_LOCK_EN
   logic lock_q, lock_d;
   logic own_q, own_d;

   // A held lock masks the non-owner out of arbitration entirely
   assign v0_elig = in0_valid & ~(lock_q & own_q);
   assign v1_elig = in1_valid & ~(lock_q & ~own_q);
`else
   assign v0_elig = in0_valid;
   assign v1_elig = in1_valid;
`endif

   assign load  = ~valid_q | out_ready;
   assign pick1 = v1_elig & (~v0_elig | prio_q);
   assign grant = ~rst & load & (v0_elig | v1_elig);

   assign in0_ready = grant & ~pick1;
   assign in1_ready = grant & pick1;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      if (grant) begin
         data_d  = pick1 ? in1_data : in0_data;
         valid_d = 1'b1;
         sel_d   = pick1;
         prio_d  = ~pick1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

`ifdef ARB_LOCK_EN
   always_comb begin
      lock_d = lock_q;
      own_d  = own_q;
      if (grant) begin
         lock_d = in_lock[pick1];
         own_d  = pick1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 1'b0;
         own_q  <= 1'b0;
      end else begin
         lock_q <= lock_d;
         own_q  <= own_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         sel_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         prio_q  <= prio_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_sel   = sel_q;

endmodule

// File: doc/mux_2x1_rr_arb.md
# mux_2x1_rr_arb

Round-robin arbiter that shares one `mux_2x1`-style datapath between two valid/ready requesters and drives a single registered output channel. Each cycle it picks one requester, steers its data through the 2:1 select, and captures it in a one-entry output register. It sits in front of any single-consumer resource fed by two producers.

## Interface
- `WIDTH`, 8, data width of each requester and of the output.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in0_data`  in  WIDTH  requester 0 payload.
- `in0_valid`  in  1  requester 0 has a beat.
- `in0_ready`  out  1  requester 0 beat accepted this cycle.
- `in1_data`  in  WIDTH  requester 1 payload.
- `in1_valid`  in  1  requester 1 has a beat.
- `in1_ready`  out  1  requester 1 beat accepted this cycle.
- `in_lock`  in  2  per-requester lock flag, sampled with the accepted beat. Present only with `ARB_LOCK_EN`.
- `out_data`  out  WIDTH  registered payload.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_sel`  out  1  source of the beat in the output register: 0 = in0, 1 = in1.

## Operation
- Load condition: `load = !out_valid || out_ready`.
- Grant, combinational:
  - Only when `load` = 1 and at least one `inN_valid` = 1.
  - One valid requester: it wins.
  - Both valid: the requester indicated by the priority pointer `prio` wins.
- `inN_ready` = grant[N]. The two readys are never both 1. A ready may depend on the valids in the same cycle.
- On grant to N, at the clock edge:
  - `out_data` <= `inN_data` (2:1 select by N).
  - `out_sel` <= N.
  - `out_valid` <= 1.
  - `prio` <= !N.
- On `out_ready` = 1 with no grant: `out_valid` <= 0; `out_data` and `out_sel` hold.
- `out_valid` = 0 with `out_ready` = 1: no effect.
- Output stable while `out_valid` = 1 and `out_ready` = 0: `out_data` and `out_sel` hold, and both readys are 0.
- Priority pointer `prio` (internal, 1 bit) selects the preferred requester on contention.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0.
  - `prio` = 0, so requester 0 wins the first contention.
  - Lock inactive.
  - `in0_ready` and `in1_ready` = 0 for as long as `rst` is high.
- Latency: accepted beat appears on `out_*` the cycle after its `inN_ready`.
- Throughput:
  - One beat per cycle when `out_ready` is held at 1.
  - Under continuous contention, grants alternate 0,1,0,1.
- Simultaneous drain and load (`out_valid` = 1, `out_ready` = 1, grant): the old beat transfers and the new beat is registered in the same edge; `out_valid` stays 1.
- Reset mid-operation: any beat in the output register is dropped without transfer. No partial state survives.
- A requester that deasserts valid before it is granted is simply skipped; the arbiter does not remember requests.

## Configuration
- Macro: `ARB_LOCK_EN`.
- Defined:
  - `in_lock` port exists.
  - A beat accepted from N with `in_lock[N]` = 1 sets lock owner = N.
  - While the lock is set, only N may be granted, even if the other requester is valid. Requester !N sees ready = 0.
  - The lock clears when a beat from N is accepted with `in_lock[N]` = 0.
  - `prio` still updates to !N on that clearing grant.
  - Reset clears the lock.
- Undefined:
  - `in_lock` port absent.
  - Pure round-robin as described above; no lock state is synthesized.

## Test plan
- Reset: hold `rst` 2 cycles with both valids = 1 -> both readys = 0, `out_valid` = 0, `out_data` = 0. After release, first grant goes to in0.
- Single requester: in0 sends 0x11, 0x22, 0x33 back-to-back with `out_ready` = 1 -> `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after acceptance, with `out_sel` = 0.
- Contention: both valid continuously, in0 = 0xA0, in1 = 0xB1, `out_ready` = 1 -> `out_sel` sequence 0,1,0,1 and `out_data` alternates 0xA0, 0xB1.
- Backpressure: `out_valid` = 1 holding 0x5C with `out_ready` = 0 for 3 cycles and both requesters valid -> `out_data` stays 0x5C and both readys stay 0. Raising `out_ready` gives a same-edge drain and load of the prio-selected requester.
- Reset mid-operation: assert `rst` while `out_valid` = 1 -> next cycle `out_valid` = 0 and `prio` = 0.
- `ARB_LOCK_EN` defined: in1 sends 3 beats with lock = 1,1,0 while in0 is valid throughout -> grants go 1,1,1 then 0. in0_ready stays 0 during the lock.
